alpha_data_emulator: RTL
========================

Name: alpha_data_emulator

Overview:
- Transmitter side of the ALPHA serial readout link. It generates the single-ended data_a bitstream that the ALPHA ASIC drives on data_a_out.
- Frame format: header word, WORDS_PER_FRAME data words, footer word. Each word is 16 bits, sent MSB first, one bit per clock.
- Used on the althea board to loop back into alpha_readout, so the receiver can be tested without an ASIC. Sits in the sysclk domain alongside alpha_control.

Parameters:
- WORDS_PER_FRAME, 8, number of data words between header and footer (1..255).
- HEADER_WORD, 16'hb5a3, fixed header pattern.
- FOOTER_WORD, 16'hf00d, fixed footer pattern.
- FILL_WORD, 16'hdead, word sent when a data word is needed and the source is not ready.
- GAP_BITS, 16, minimum idle-low bits after a footer before the next frame (≥1).

Ports:
- clock  input  1  sysclk.
- reset  input  1  synchronous, active-high.
- start  input  1  frame request (token-in equivalent); sampled only in IDLE.
- word_in  input  16  next data word.
- word_valid  input  1  word_in holds valid data.
- word_ready  output  1  one-cycle pulse: word_in is consumed this cycle if word_valid is high.
- data_a  output  1  serial stream; idles low.
- busy  output  1  high in every state except IDLE.
- header  output  1  high while header bits are on data_a.
- meat  output  1  high while data-word bits are on data_a.
- footer  output  1  high while footer bits are on data_a.
- strobe  output  1  one-cycle pulse on the 4th bit of each data-word nybble.
- msn  output  1  high with strobe when that nybble is bits [15:12].
- nybble  output  4  the nybble just completed; valid with strobe.
- tok_out  output  1  one-cycle pulse on the cycle after the last footer bit.
- underflow  output  1  sticky; set whenever FILL_WORD is substituted.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shift register 0. Reset applied mid-frame aborts immediately; data_a is low on the next cycle.
- States: IDLE → HEADER → MEAT → FOOTER → GAP → IDLE.
- IDLE: when start=1, load HEADER_WORD and go to HEADER. The first header bit appears on data_a on the following cycle. start in any other state is ignored (no queuing).
- Each word state drives shreg[15] while bit_cnt counts 0..15. On bit_cnt=15 the next word is loaded:
  - HEADER → data word 0, then MEAT.
  - MEAT, word_cnt<WORDS_PER_FRAME-1 → next data word, stay in MEAT.
  - MEAT, last data word → FOOTER_WORD, then FOOTER.
  - FOOTER → GAP, tok_out=1 on the first GAP cycle.
- Data-word load: word_ready=1 on each load cycle that fetches a data word, and only then.
  - word_valid=1: load word_in.
  - word_valid=0: load FILL_WORD and set underflow; the frame never stalls.
- Stream length: exactly 16*(WORDS_PER_FRAME+2) bits, contiguous, with no gaps between words.
- GAP: data_a=0 for GAP_BITS cycles, then IDLE. The earliest next start is accepted in IDLE, so the inter-frame spacing is ≥ GAP_BITS+1 cycles.
- header/meat/footer align with the bits on data_a (registered together with data_a).
- strobe: in MEAT when bit_cnt[1:0]=3. nybble is the 4 bits sent on bit_cnt-3..bit_cnt; msn=1 when bit_cnt=3.
- underflow clears only on reset.
- busy=1 from the cycle after start is accepted through the last GAP cycle.
- Widths: word_cnt is 8 bits. bit_cnt is 4 bits and wraps 15→0 at each word boundary.

Optional Feature:
- Macro: ALPHA_EMULATOR_COUNTER_PATTERN_EN.
- With the macro: adds input use_counter (1 bit). When use_counter=1, data words come from an internal 16-bit counter that resets to 0 and increments per word loaded, carried across frames. word_ready stays 0 and underflow is never set.
- Without the macro: no port, no counter; words come only from word_in.

Decomposition:
- Shared package alpha_pkg:
  - state enum {IDLE, HEADER, MEAT, FOOTER, GAP};
  - constants ALPHA_WORD_BITS=16 and ALPHA_NYBBLE_BITS=4;
  - default HEADER/FOOTER patterns, shared with alpha_readout.
- One sub-module: alpha_word_serializer. It holds the 16-bit load/shift register plus bit_cnt and emits load_next on bit 15. The parent holds the FSM, word_cnt and flags.

Test Plan:
- Reset, then start=1 for 1 cycle, WORDS_PER_FRAME=2, word_valid=1, words 16'h1234, 16'habcd → data_a = b5a3,1234,abcd,f00d serial, 64 bits. header high for 16 cycles, then meat for 32, then footer for 16. tok_out pulses at bit 64+1. strobe pulses 8 times with nybbles 1,2,3,4,a,b,c,d; msn is set for nybbles 1 and a.
- word_valid=0 for the whole frame → both data words are 16'hdead, underflow=1 and stays 1 after the frame. word_ready still pulses twice.
- start held high continuously, GAP_BITS=16 → frames separated by exactly 17 low cycles; start pulses during a frame are ignored.
- reset asserted at bit 20 of a frame → next cycle data_a=0, busy=0, all flags 0. A start issued afterwards produces a clean full frame.
- Loop back into alpha_readout, 1000 frames of random words → received data_word sequence equals the sent sequence, with no header or footer errors.
- With ALPHA_EMULATOR_COUNTER_PATTERN_EN and use_counter=1 → first frame data words 0..7, second frame 8..15, word_ready never pulses.

Source files
------------

// File: rtl/alpha_pkg.sv
// Shared ALPHA link definitions: frame states, word geometry and default
// header/footer/fill patterns common to the emulator and alpha_readout.
package alpha_pkg;

  localparam int unsigned ALPHA_WORD_BITS   = 16;
  localparam int unsigned ALPHA_NYBBLE_BITS = 4;
  localparam int unsigned ALPHA_BIT_CNT_W   = $clog2(ALPHA_WORD_BITS);

  typedef logic [ALPHA_WORD_BITS-1:0]   alpha_word_t;
  typedef logic [ALPHA_NYBBLE_BITS-1:0] alpha_nybble_t;
  typedef logic [ALPHA_BIT_CNT_W-1:0]   alpha_bit_cnt_t;

  localparam alpha_word_t ALPHA_HEADER_DEFAULT = 16'hb5a3;
  localparam alpha_word_t ALPHA_FOOTER_DEFAULT = 16'hf00d;
  localparam alpha_word_t ALPHA_FILL_DEFAULT   = 16'hdead;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    MEAT,
    FOOTER,
    GAP
  } alpha_state_e;

endpackage

// File: rtl/alpha_data_emulator_if.sv
// Data-word source handshake feeding the ALPHA data emulator.
interface alpha_data_emulator_if;
  import alpha_pkg::*;

  alpha_word_t word_in;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);

endinterface

// File: rtl/alpha_word_serializer.sv
// 16-bit load/shift register, MSB first, with a bit counter that wraps at
// each word boundary and flags the last bit of the current word.
module alpha_word_serializer
  import alpha_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           shift,
  input  alpha_word_t    load_word,
  output logic [1:0]     top_bits,
  output alpha_bit_cnt_t bit_cnt,
  output logic           load_next
);

  alpha_word_t sreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= load_word;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= {sreg[ALPHA_WORD_BITS-2:0], 1'b0};
      bit_cnt <= bit_cnt + ALPHA_BIT_CNT_W'(1);
    end
  end

  assign top_bits  = sreg[ALPHA_WORD_BITS-1 -: 2];
  assign load_next = (bit_cnt == ALPHA_BIT_CNT_W'(ALPHA_WORD_BITS-1));

endmodule

// File: rtl/alpha_data_emulator.sv
// ALPHA serial readout transmitter: header, WORDS_PER_FRAME data words, footer,
// then an idle-low gap. Optional counter data source: ALPHA_EMULATOR_COUNTER_PATTERN_EN.
module alpha_data_emulator
  import alpha_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 8,
  parameter alpha_word_t HEADER_WORD     = ALPHA_HEADER_DEFAULT,
  parameter alpha_word_t FOOTER_WORD     = ALPHA_FOOTER_DEFAULT,
  parameter alpha_word_t FILL_WORD       = ALPHA_FILL_DEFAULT,
  parameter int unsigned GAP_BITS        = 16
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
`ifdef ALPHA_EMULATOR_COUNTER_PATTERN_EN
  input  logic                  use_counter,
`endif
  alpha_data_emulator_if.slave  word_if,
  output logic                  data_a,
  output logic                  busy,
  output logic                  header,
  output logic                  meat,
  output logic                  footer,
  output logic                  strobe,
  output logic                  msn,
  output alpha_nybble_t         nybble,
  output logic                  tok_out,
  output logic                  underflow
);

  localparam int unsigned GAP_W     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS - 1);
  localparam logic [7:0]       LAST_WORD = 8'(WORDS_PER_FRAME - 1);

  alpha_state_e   state, next_state;
  logic [7:0]     word_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]     hist;
  logic [1:0]     top_bits;
  alpha_bit_cnt_t bit_cnt;
  logic           load_next, load, shift, fetch, last_word, ready_soon, pattern_sel;
  alpha_word_t    load_word, data_word;

  alpha_word_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_word (load_word),
    .top_bits  (top_bits),
    .bit_cnt   (bit_cnt),
    .load_next (load_next)
  );

  // Data source: counter pattern when selected, else word_in or fill on underrun
`ifdef ALPHA_EMULATOR_COUNTER_PATTERN_EN
  alpha_word_t pat_cnt;
  assign pattern_sel = use_counter;

  always_ff @(posedge clock) begin
    if (reset)                    pat_cnt <= '0;
    else if (fetch && use_counter) pat_cnt <= pat_cnt + 16'd1;
  end

  always_comb begin
    data_word = word_if.word_valid ? word_if.word_in : FILL_WORD;
    if (use_counter) data_word = pat_cnt;
  end
`else
  assign pattern_sel = 1'b0;
  assign data_word   = word_if.word_valid ? word_if.word_in : FILL_WORD;
`endif

  assign last_word  = (word_cnt == LAST_WORD);
  assign ready_soon = !pattern_sel && (bit_cnt == ALPHA_BIT_CNT_W'(ALPHA_WORD_BITS-2)) &&
                      ((state == HEADER) || ((state == MEAT) && !last_word));
  assign data_a     = top_bits[1];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    fetch      = 1'b0;
    load_word  = '0;
    unique case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        load_word  = HEADER_WORD;
        next_state = HEADER;
      end
      HEADER: begin
        shift = 1'b1;
        if (load_next) begin
          load       = 1'b1;
          fetch      = 1'b1;
          load_word  = data_word;
          next_state = MEAT;
        end
      end
      MEAT: begin
        shift = 1'b1;
        if (load_next) begin
          load = 1'b1;
          if (last_word) begin
            load_word  = FOOTER_WORD;
            next_state = FOOTER;
          end else begin
            fetch     = 1'b1;
            load_word = data_word;
          end
        end
      end
      FOOTER: begin
        shift = 1'b1;
        // Loading zero leaves the line low through the gap
        if (load_next) begin
          load       = 1'b1;
          next_state = GAP;
        end
      end
      GAP: if (gap_cnt == GAP_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame counters: data-word index and gap length
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == HEADER)                          word_cnt <= '0;
      else if (state == MEAT && load_next && !last_word) word_cnt <= word_cnt + 8'd1;
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

  // Registered status; flags are computed one cycle ahead to align with data_a
  always_ff @(posedge clock) begin
    if (reset) begin
      busy               <= 1'b0;
      header             <= 1'b0;
      meat               <= 1'b0;
      footer             <= 1'b0;
      strobe             <= 1'b0;
      msn                <= 1'b0;
      nybble             <= '0;
      tok_out            <= 1'b0;
      underflow          <= 1'b0;
      hist               <= '0;
      word_if.word_ready <= 1'b0;
    end else begin
      busy               <= (next_state != IDLE);
      header             <= (next_state == HEADER);
      meat               <= (next_state == MEAT);
      footer             <= (next_state == FOOTER);
      tok_out            <= (state == FOOTER) && load_next;
      strobe             <= (state == MEAT) && (bit_cnt[1:0] == 2'd2);
      msn                <= (state == MEAT) && (bit_cnt == ALPHA_BIT_CNT_W'(2));
      if ((state == MEAT) && (bit_cnt[1:0] == 2'd2)) nybble <= {hist, top_bits};
      hist               <= {hist[0], top_bits[1]};
      word_if.word_ready <= ready_soon;
      underflow          <= underflow | (fetch && !word_if.word_valid && !pattern_sel);
    end
  end

endmodule
